// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding imem read at a time, byte-swapped into a FIFO_DEPTH prefetch buffer.
// First instruction 3 cycles after reset; no request while the buffer is full; redirect flushes the buffer and cancels the in-flight read.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_ir,
    output logic [31:0] inst_pc
);
    localparam int          AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        REQ,
        RESP,
        DROP
    } state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   ir_mem [FIFO_DEPTH];
    logic [31:0]   pc_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;
    logic [31:0]   rdata_swap;
    logic          unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];
    assign rdata_swap     = {imem_rdata[7:0], imem_rdata[15:8], imem_rdata[23:16], imem_rdata[31:24]};

    // Request is a decode of state and count only; reset_n keeps it low while reset is held.
    assign imem_req   = reset_n && (state == REQ) && (count < DEPTH);
    assign imem_addr  = fetch_pc;
    assign inst_valid = (count != '0);
    assign inst_ir    = ir_mem[rd_ptr];
    assign inst_pc    = pc_mem[rd_ptr];

    assign push = (state == RESP) && imem_rvalid && !redirect;
    assign pop  = inst_valid && inst_ready && !redirect;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= REQ;
            fetch_pc <= RESET_PC;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (redirect) begin
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            case (state)
                REQ:     state <= (imem_req && imem_gnt) ? DROP : REQ;
                RESP:    state <= imem_rvalid ? REQ : DROP;
                DROP:    state <= imem_rvalid ? REQ : DROP;
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (imem_req && imem_gnt) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (imem_rvalid) begin
                        fetch_pc <= fetch_pc + 32'd4;
                        state    <= REQ;
                    end
                end
                DROP: begin
                    if (imem_rvalid) begin
                        state <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ir_mem[wr_ptr] <= rdata_swap;
            pc_mem[wr_ptr] <= fetch_pc;
        end
    end
endmodule
